// File: rtl/apb_master_arbiter_pkg.sv
// Shared types for the two-requester APB master sequencer: FSM states,
// request/response records and default bus widths.
package apb_master_arbiter_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester handshakes plus the shared APB master port of the arbiter.
interface apb_master_arbiter_if
  import apb_master_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = APB_ADDR_W,
  parameter int unsigned DATA_W = APB_DATA_W
);
  logic              io_m0_valid;
  logic [ADDR_W-1:0] io_m0_addr;
  logic              io_m0_write;
  logic [DATA_W-1:0] io_m0_wdata;
  logic              io_m0_ready;
  logic              io_m0_rvalid;
  logic [DATA_W-1:0] io_m0_rdata;
  logic              io_m0_err;

  logic              io_m1_valid;
  logic [ADDR_W-1:0] io_m1_addr;
  logic              io_m1_write;
  logic [DATA_W-1:0] io_m1_wdata;
  logic              io_m1_ready;
  logic              io_m1_rvalid;
  logic [DATA_W-1:0] io_m1_rdata;
  logic              io_m1_err;

  logic [ADDR_W-1:0] io_out_paddr;
  logic              io_out_pwrite;
  logic              io_out_psel;
  logic              io_out_penable;
  logic [DATA_W-1:0] io_out_pwdata;
  logic [DATA_W-1:0] io_out_prdata;
  logic              io_out_pready;
  logic              io_out_pslverr;

  // Arbiter side: accepts requests, drives the APB port.
  modport master (
    input  io_m0_valid, io_m0_addr, io_m0_write, io_m0_wdata,
    output io_m0_ready, io_m0_rvalid, io_m0_rdata, io_m0_err,
    input  io_m1_valid, io_m1_addr, io_m1_write, io_m1_wdata,
    output io_m1_ready, io_m1_rvalid, io_m1_rdata, io_m1_err,
    output io_out_paddr, io_out_pwrite, io_out_psel, io_out_penable, io_out_pwdata,
    input  io_out_prdata, io_out_pready, io_out_pslverr
  );

  // Environment side: requesters and the APB decoder/slave.
  modport slave (
    output io_m0_valid, io_m0_addr, io_m0_write, io_m0_wdata,
    input  io_m0_ready, io_m0_rvalid, io_m0_rdata, io_m0_err,
    output io_m1_valid, io_m1_addr, io_m1_write, io_m1_wdata,
    input  io_m1_ready, io_m1_rvalid, io_m1_rdata, io_m1_err,
    input  io_out_paddr, io_out_pwrite, io_out_psel, io_out_penable, io_out_pwdata,
    output io_out_prdata, io_out_pready, io_out_pslverr
  );
endinterface

// File: rtl/apb_master_arbiter_rr_arb2.sv
// Two-way round-robin picker; on a tie the requester other than
// i_last_grant wins. Purely combinational.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  input  logic       i_en,
  output logic [1:0] o_gnt,
  output logic       o_gnt_idx
);
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = 1'b0;
    if (i_en) begin
      case (i_req)
        2'b01: begin
          o_gnt     = 2'b01;
          o_gnt_idx = 1'b0;
        end
        2'b10: begin
          o_gnt     = 2'b10;
          o_gnt_idx = 1'b1;
        end
        2'b11: begin
          o_gnt_idx = ~i_last_grant;
          o_gnt     = i_last_grant ? 2'b01 : 2'b10;
        end
        default: begin
          o_gnt     = '0;
          o_gnt_idx = 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between two single-transfer requesters with
// round-robin arbitration, SETUP/ACCESS sequencing and an ACCESS timeout.
module apb_master_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  apb_master_arbiter_if.master  bus
);
  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  apb_state_e        r_state;
  logic              r_last_grant;
  logic              r_owner;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_psel;
  logic              r_penable;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_rvalid;
  logic [DATA_W-1:0] r_rdata0, r_rdata1;
  logic              r_err0, r_err1;

  logic [1:0]        w_gnt;
  logic              w_gnt_idx;
  logic              w_timeout;
  logic [DATA_W-1:0] w_rsp_rdata;
  logic              w_rsp_err;

  rr_arb2 u_arb (
    .i_req        ({bus.io_m1_valid, bus.io_m0_valid}),
    .i_last_grant (r_last_grant),
    .i_en         ((r_state == ST_IDLE) && !reset),
    .o_gnt        (w_gnt),
    .o_gnt_idx    (w_gnt_idx)
  );

  assign w_timeout   = (TIMEOUT != 0) && !bus.io_out_pready && (r_cnt == CNT_LAST);
  // An aborted access reports no data; writes never return data.
  assign w_rsp_rdata = (bus.io_out_pready && !r_pwrite) ? bus.io_out_prdata : '0;
  assign w_rsp_err   = bus.io_out_pready ? bus.io_out_pslverr : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_paddr      <= '0;
      r_pwrite     <= 1'b0;
      r_pwdata     <= '0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_cnt        <= '0;
      r_rvalid     <= '0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
    end else begin
      r_rvalid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|w_gnt) begin
            r_paddr      <= w_gnt_idx ? bus.io_m1_addr  : bus.io_m0_addr;
            r_pwrite     <= w_gnt_idx ? bus.io_m1_write : bus.io_m0_write;
            r_pwdata     <= w_gnt_idx ? bus.io_m1_wdata : bus.io_m0_wdata;
            r_last_grant <= w_gnt_idx;
            r_owner      <= w_gnt_idx;
            r_psel       <= 1'b1;
            r_state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (bus.io_out_pready || w_timeout) begin
            r_psel            <= 1'b0;
            r_penable         <= 1'b0;
            r_state           <= ST_IDLE;
            r_rvalid[r_owner] <= 1'b1;
            if (r_owner) begin
              r_rdata1 <= w_rsp_rdata;
              r_err1   <= w_rsp_err;
            end else begin
              r_rdata0 <= w_rsp_rdata;
              r_err0   <= w_rsp_err;
            end
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.io_m0_ready    = w_gnt[0];
  assign bus.io_m1_ready    = w_gnt[1];
  assign bus.io_m0_rvalid   = r_rvalid[0];
  assign bus.io_m1_rvalid   = r_rvalid[1];
  assign bus.io_m0_rdata    = r_rdata0;
  assign bus.io_m1_rdata    = r_rdata1;
  assign bus.io_m0_err      = r_err0;
  assign bus.io_m1_err      = r_err1;
  assign bus.io_out_paddr   = r_paddr;
  assign bus.io_out_pwrite  = r_pwrite;
  assign bus.io_out_pwdata  = r_pwdata;
  assign bus.io_out_psel    = r_psel;
  assign bus.io_out_penable = r_penable;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: directed transfers push expected
// grants, SETUP contents, phase lengths and responses; negedge monitors check.
module tb_apb_master_arbiter;
  import apb_master_arbiter_pkg::*;

  localparam int unsigned TO = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  apb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master_arbiter #(.TIMEOUT(TO), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          m;
    logic [31:0] rdata;
    logic        err;
  } exp_rsp_t;

  int n_tests = 0;
  int n_fail  = 0;

  int       q_gnt[$];
  apb_req_t q_setup[$];
  exp_rsp_t q_rsp[$];
  int       q_acc[$];

  int          g_wait   = 0;
  logic [31:0] g_prdata = '0;
  logic        g_slverr = 1'b0;
  bit          skip_len = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string detail);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // APB slave: g_wait low-ready ACCESS cycles then ready; negative = never.
  // pslverr is driven high while not ready, which the arbiter must ignore.
  initial begin
    int acc;
    acc = 0;
    bus.io_out_pready  = 1'b0;
    bus.io_out_pslverr = 1'b0;
    bus.io_out_prdata  = '0;
    forever begin
      @(negedge clk);
      if (bus.io_out_psel && bus.io_out_penable) begin
        bus.io_out_pready  = (g_wait >= 0) && (acc == g_wait);
        bus.io_out_pslverr = bus.io_out_pready ? g_slverr : 1'b1;
        bus.io_out_prdata  = bus.io_out_pready ? g_prdata : 32'hBAD0_BAD0;
        acc++;
      end else begin
        acc = 0;
        bus.io_out_pready  = 1'b0;
        bus.io_out_pslverr = 1'b0;
        bus.io_out_prdata  = '0;
      end
    end
  end

  // Monitors: grants, SETUP/ACCESS contents, phase lengths, responses.
  apb_req_t cur_req;
  int  c_sel = 0, c_en = 0;
  bit  prev_sel = 1'b0;
  always @(negedge clk) begin
    if (!reset && (bus.io_m0_ready || bus.io_m1_ready)) begin
      check("ready_both", {bus.io_m1_ready, bus.io_m0_ready} == 2'b11, 0);
      check("ready_outside_idle", bus.io_out_psel, 0);
      if (q_gnt.size() == 0) fail_now("unexpected_grant", "ready with no grant expected");
      else check("grant_order", bus.io_m1_ready ? 1 : 0, q_gnt.pop_front());
    end
    if (bus.io_out_psel && !bus.io_out_penable) begin
      if (q_setup.size() == 0) fail_now("unexpected_setup", "SETUP with no transfer expected");
      else begin
        cur_req = q_setup.pop_front();
        check("setup_paddr",  bus.io_out_paddr,  cur_req.addr);
        check("setup_pwrite", bus.io_out_pwrite, cur_req.write);
        check("setup_pwdata", bus.io_out_pwdata, cur_req.wdata);
      end
    end else if (bus.io_out_psel && bus.io_out_penable) begin
      check("access_stable", {bus.io_out_paddr, bus.io_out_pwdata},
            {cur_req.addr, cur_req.wdata});
    end
    if (bus.io_out_psel) begin
      c_sel++;
      if (bus.io_out_penable) c_en++;
    end else if (prev_sel) begin
      if (skip_len) skip_len = 1'b0;
      else if (q_acc.size() == 0) fail_now("unexpected_psel", "psel pulse with no transfer expected");
      else begin
        int a;
        a = q_acc.pop_front();
        check("psel_cycles",    c_sel, a + 1);
        check("penable_cycles", c_en,  a);
      end
      c_sel = 0;
      c_en  = 0;
    end
    prev_sel = bus.io_out_psel;
    if (bus.io_m0_rvalid || bus.io_m1_rvalid) begin
      check("rvalid_both", bus.io_m0_rvalid && bus.io_m1_rvalid, 0);
      check("psel_low_at_rvalid", {bus.io_out_psel, bus.io_out_penable}, 0);
      if (q_rsp.size() == 0) fail_now("unexpected_rvalid", "response with none expected");
      else begin
        exp_rsp_t e;
        e = q_rsp.pop_front();
        check("rsp_requester", bus.io_m1_rvalid ? 1 : 0, e.m);
        check("rsp_rdata", e.m != 0 ? bus.io_m1_rdata : bus.io_m0_rdata, e.rdata);
        check("rsp_err",   e.m != 0 ? bus.io_m1_err   : bus.io_m0_err,   e.err);
      end
    end
  end

  task automatic drive(input int m, input logic v, input logic [31:0] a,
                       input logic w, input logic [31:0] d);
    if (m == 0) begin
      bus.io_m0_valid = v; bus.io_m0_addr = a; bus.io_m0_write = w; bus.io_m0_wdata = d;
    end else begin
      bus.io_m1_valid = v; bus.io_m1_addr = a; bus.io_m1_write = w; bus.io_m1_wdata = d;
    end
  endtask

  function automatic logic rdy(input int m);
    return (m == 0) ? bus.io_m0_ready : bus.io_m1_ready;
  endfunction

  // Issue one transfer; expectations are queued once the request is accepted.
  task automatic issue(input int m, input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_acc,
                       input bit track);
    int n;
    exp_rsp_t e;
    apb_req_t r;
    n = 0;
    @(posedge clk);
    #1;
    drive(m, 1'b1, a, w, d);
    @(negedge clk);
    while (!rdy(m) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(m)) begin
      fail_now($sformatf("accept_timeout_m%0d", m), "ready never asserted");
      drive(m, 1'b0, '0, 1'b0, '0);
      return;
    end
    r = '{addr: a, write: w, wdata: d};
    q_setup.push_back(r);
    if (track) begin
      e.m = m; e.rdata = exp_rdata; e.err = exp_err;
      q_rsp.push_back(e);
      q_acc.push_back(exp_acc);
    end
    @(posedge clk);
    #1;
    drive(m, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q_rsp.size() != 0 || q_acc.size() != 0 || q_gnt.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("drain_timeout", "expected responses never arrived");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    drive(0, 1'b0, '0, 1'b0, '0);
    drive(1, 1'b0, '0, 1'b0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_psel_penable", {bus.io_out_psel, bus.io_out_penable}, 0);
    check("rst_paddr_pwrite", {bus.io_out_paddr, bus.io_out_pwrite}, 0);
    check("rst_pwdata", bus.io_out_pwdata, 0);
    check("rst_ready_rvalid", {bus.io_m0_ready, bus.io_m1_ready, bus.io_m0_rvalid, bus.io_m1_rvalid}, 0);
    check("rst_rdata", {bus.io_m0_rdata, bus.io_m1_rdata}, 0);
    check("rst_err", {bus.io_m0_err, bus.io_m1_err}, 0);
    reset = 1'b0;

    // Single read, ready in first ACCESS cycle.
    g_wait = 0; g_prdata = 32'hDEAD_BEEF; g_slverr = 1'b0;
    q_gnt.push_back(0);
    issue(0, 32'hF100_0010, 1'b0, '0, 32'hDEAD_BEEF, 1'b0, 1, 1'b1);
    wait_drain();

    // Write with 3 wait states ending in pslverr.
    g_wait = 3; g_prdata = 32'h0000_1234; g_slverr = 1'b1;
    q_gnt.push_back(1);
    issue(1, 32'hF100_0020, 1'b1, 32'hCAFE_0001, 32'h0, 1'b1, 4, 1'b1);
    wait_drain();
    check("m0_rdata_held", bus.io_m0_rdata, 32'hDEAD_BEEF);
    check("m1_err_held", bus.io_m1_err, 1);

    // Both requesters streaming writes: strict alternation from m0.
    g_wait = 0; g_prdata = 32'h5555_5555; g_slverr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q_gnt.push_back(0);
      q_gnt.push_back(1);
    end
    fork
      for (int i = 0; i < 4; i++)
        issue(0, 32'hF100_0100 + 32'(4 * i), 1'b1, 32'h10 + 32'(i), 32'h0, 1'b0, 1, 1'b1);
      for (int j = 0; j < 4; j++)
        issue(1, 32'hF100_0200 + 32'(4 * j), 1'b1, 32'h20 + 32'(j), 32'h0, 1'b0, 1, 1'b1);
    join
    wait_drain();

    // Timeout abort, then a normal transfer.
    g_wait = -1;
    q_gnt.push_back(0);
    issue(0, 32'hF100_0030, 1'b0, '0, 32'h0, 1'b1, TO, 1'b1);
    wait_drain();
    g_wait = 1; g_prdata = 32'hA5A5_0001; g_slverr = 1'b0;
    q_gnt.push_back(1);
    issue(1, 32'hF100_0040, 1'b0, '0, 32'hA5A5_0001, 1'b0, 2, 1'b1);
    wait_drain();

    // Reset during ACCESS: no response, tie afterwards goes to m0.
    g_wait = -1;
    q_gnt.push_back(0);
    issue(0, 32'hF100_0050, 1'b0, '0, 32'h0, 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_reset_in_access", {bus.io_out_psel, bus.io_out_penable}, 2'b11);
    skip_len = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_psel_penable", {bus.io_out_psel, bus.io_out_penable}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    g_wait = 0; g_prdata = 32'h0000_0077; g_slverr = 1'b0;
    q_gnt.push_back(0);
    q_gnt.push_back(1);
    fork
      issue(0, 32'hF100_0060, 1'b0, '0, 32'h0000_0077, 1'b0, 1, 1'b1);
      issue(1, 32'hF100_0070, 1'b1, 32'h0000_0099, 32'h0, 1'b0, 1, 1'b1);
    join
    wait_drain();

    check("leftover_setup", q_setup.size(), 0);
    check("leftover_rsp", q_rsp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
